// File: rtl/exec_alu_sequencer.sv
// ---------------------------------------------------------------------------
// exec_alu_sequencer
//
// Execute-stage controller that time-shares a single external combinational
// alu2 for three jobs that would otherwise need three separate ALUs:
//   1. the main operation (rs1 op rs2/imm),
//   2. the immediate shift (imm << 1) used by branches,
//   3. the branch-target add (pc + (imm << 1)).
// Decode hands an op over with a valid/ready handshake, the sequencer walks
// it through the shared ALU over several cycles, and presents the result to
// memory/writeback with a second valid/ready handshake.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset          synchronous, active-high
//   in_valid       upstream op valid
//   in_ready       sequencer can accept (only while idle)
//   pc, imm        PC and immediate of the op
//   rs1_data       source register 1
//   rs2_data       source register 2
//   alu_src        1: operand B is imm, 0: operand B is rs2_data
//   branch         op is a conditional branch
//   alu_ctrl       alu2 control code for the main op (passed through as-is)
//   alu_a, alu_b   operands driven to the shared alu2
//   alu_op         control code driven to the shared alu2
//   alu_y          shared alu2 result, valid in the same cycle
//   out_valid      result valid towards downstream
//   out_ready      downstream accepts
//   result         main ALU result
//   zero           result == 0
//   branch_target  pc + (imm << 1) for branches, 0 otherwise
//   branch_taken   branch & zero
//   busy           sequencer is not idle
// ---------------------------------------------------------------------------
module exec_alu_sequencer #(
    parameter int          XLEN   = 64,
    parameter logic [3:0]  OP_ADD = 4'b0010,
    parameter logic [3:0]  OP_SLL = 4'b0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            alu_src,
    input  logic            branch,
    input  logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [XLEN-1:0] branch_target,
    output logic            branch_taken,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC  = 3'd1,
        SHIFT = 3'd2,
        ADD   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state;

    // Operands captured at the accept edge; the upstream bus is free to
    // change afterwards because nothing else samples it until we are idle.
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic            alu_src_q;
    logic            branch_q;
    logic [3:0]      alu_ctrl_q;

    // Shifted immediate, carried from the SHIFT step into the ADD step.
    logic [XLEN-1:0] tgt_q;

    // Constant 1 used as the shift amount for imm << 1.
    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    // Shared ALU steering. Depends only on the state register and the
    // latched operands, so the ALU inputs never follow the live upstream
    // bus. When idle or done the ALU is parked on a harmless 0 + 0.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_ADD;
        case (state)
            EXEC: begin
                alu_a  = rs1_q;
                alu_b  = alu_src_q ? imm_q : rs2_q;
                alu_op = alu_ctrl_q;
            end
            SHIFT: begin
                alu_a  = imm_q;
                alu_b  = ONE;
                alu_op = OP_SLL;
            end
            ADD: begin
                alu_a  = pc_q;
                alu_b  = tgt_q;
                alu_op = OP_ADD;
            end
            default: begin
                alu_a  = '0;
                alu_b  = '0;
                alu_op = OP_ADD;
            end
        endcase
    end

    // Sequencer FSM with registered handshake and result outputs.
    // Non-branch ops go EXEC -> DONE; branches take two extra ALU passes
    // (SHIFT then ADD) to build the target. The main result is captured in
    // EXEC and then held untouched, so the zero flag that branch_taken uses
    // in ADD is the one belonging to this op. in_ready and busy are updated
    // together with every state change so they always mirror "state == IDLE".
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
            result        <= '0;
            zero          <= 1'b0;
            branch_target <= '0;
            branch_taken  <= 1'b0;
            pc_q          <= '0;
            imm_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            alu_src_q     <= 1'b0;
            branch_q      <= 1'b0;
            alu_ctrl_q    <= '0;
            tgt_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pc_q       <= pc;
                        imm_q      <= imm;
                        rs1_q      <= rs1_data;
                        rs2_q      <= rs2_data;
                        alu_src_q  <= alu_src;
                        branch_q   <= branch;
                        alu_ctrl_q <= alu_ctrl;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end

                EXEC: begin
                    result <= alu_y;
                    zero   <= (alu_y == '0);
                    if (branch_q) begin
                        state <= SHIFT;
                    end else begin
                        // Non-branch ops report no target and never "take".
                        branch_target <= '0;
                        branch_taken  <= 1'b0;
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end
                end

                SHIFT: begin
                    // The top bit of imm falls off here, as in any 1-bit shift.
                    tgt_q <= alu_y;
                    state <= ADD;
                end

                ADD: begin
                    // Sum wraps modulo 2^XLEN inside the ALU.
                    branch_target <= alu_y;
                    branch_taken  <= zero;
                    out_valid     <= 1'b1;
                    state         <= DONE;
                end

                DONE: begin
                    // Everything is frozen until downstream takes it; even
                    // with out_ready high no new op is accepted this cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exec_alu_sequencer
//
// Bench for exec_alu_sequencer. Provides the external alu2 as a small
// behavioural block, runs a table of directed ops, a backpressure case,
// a mid-operation reset, and a batch of random ops whose expected results
// come from a plain-arithmetic reference of what an execute stage should
// produce.
// ---------------------------------------------------------------------------
module tb_exec_alu_sequencer;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        alu_src;
    logic        branch;
    logic [3:0]  alu_ctrl;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_op;
    logic [63:0] alu_y;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        zero;
    logic [63:0] branch_target;
    logic        branch_taken;
    logic        busy;

    int tests    = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic        alu_src;
        logic        branch;
        logic [3:0]  ctrl;
        logic [63:0] expResult;
        logic        expZero;
        logic [63:0] expTarget;
        logic        expTaken;
        int          expLat;
    } vec_t;

    exec_alu_sequencer #(
        .XLEN   (64),
        .OP_ADD (OP_ADD),
        .OP_SLL (OP_SLL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pc            (pc),
        .imm           (imm),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .alu_src       (alu_src),
        .branch        (branch),
        .alu_ctrl      (alu_ctrl),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_y         (alu_y),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero          (zero),
        .branch_target (branch_target),
        .branch_taken  (branch_taken),
        .busy          (busy)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the external alu2.
    function automatic logic [63:0] aluModel(input logic [3:0] op,
                                             input logic [63:0] a,
                                             input logic [63:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << b[5:0];
            OP_SLT:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_y = aluModel(alu_op, alu_a, alu_b);

    // What an execute stage should report for an op, from first principles.
    function automatic vec_t refModel(input vec_t v);
        vec_t r;
        logic [63:0] opB;
        r = v;
        opB = v.alu_src ? v.imm : v.rs2;
        r.expResult = aluModel(v.ctrl, v.rs1, opB);
        r.expZero   = (r.expResult == 64'd0);
        r.expTarget = v.branch ? (v.pc + (v.imm << 1)) : 64'd0;
        r.expTaken  = v.branch && r.expZero;
        r.expLat    = v.branch ? 4 : 2;
        return r;
    endfunction

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents an op on the upstream bus (caller is at a falling edge).
    task automatic applyStimulus(input vec_t v);
        pc       = v.pc;
        imm      = v.imm;
        rs1_data = v.rs1;
        rs2_data = v.rs2;
        alu_src  = v.alu_src;
        branch   = v.branch;
        alu_ctrl = v.ctrl;
        in_valid = 1'b1;
    endtask

    // Scribbles over the upstream bus so any late sampling shows up.
    task automatic scrambleInputs();
        pc       = {$urandom, $urandom};
        imm      = {$urandom, $urandom};
        rs1_data = {$urandom, $urandom};
        rs2_data = {$urandom, $urandom};
        alu_src  = 1'($urandom_range(0, 1));
        branch   = 1'($urandom_range(0, 1));
        alu_ctrl = 4'($urandom_range(0, 15));
    endtask

    task automatic checkResults(input vec_t v, input string tag);
        checkOutput({tag, ":out_valid"},     64'(out_valid),     64'd1);
        checkOutput({tag, ":result"},        result,             v.expResult);
        checkOutput({tag, ":zero"},          64'(zero),          64'(v.expZero));
        checkOutput({tag, ":branch_target"}, branch_target,      v.expTarget);
        checkOutput({tag, ":branch_taken"},  64'(branch_taken),  64'(v.expTaken));
        checkOutput({tag, ":in_ready"},      64'(in_ready),      64'd0);
    endtask

    // Runs one op end to end: accept, ALU pass trace, latency, results,
    // optional backpressure (with optional junk in_valid pulses), release.
    task automatic runOp(input vec_t v, input int stall, input bit junk,
                         input string tag);
        logic [3:0]  expOp[$];
        logic [63:0] expA[$];
        logic [63:0] expB[$];
        int          cyc;
        expOp.push_back(v.ctrl);
        expA.push_back(v.rs1);
        expB.push_back(v.alu_src ? v.imm : v.rs2);
        if (v.branch) begin
            expOp.push_back(OP_SLL);
            expA.push_back(v.imm);
            expB.push_back(64'd1);
            expOp.push_back(OP_ADD);
            expA.push_back(v.pc);
            expB.push_back(v.imm << 1);
        end
        out_ready = (stall == 0);
        applyStimulus(v);
        checkOutput({tag, ":in_ready_idle"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        scrambleInputs();
        cyc = 1;
        while (!out_valid && cyc < 12) begin
            checkOutput({tag, ":in_ready_busy"}, 64'(in_ready), 64'd0);
            checkOutput({tag, ":busy"},          64'(busy),     64'd1);
            if (expOp.size() > 0) begin
                checkOutput($sformatf("%s:alu_op[c%0d]", tag, cyc), 64'(alu_op), 64'(expOp.pop_front()));
                checkOutput($sformatf("%s:alu_a[c%0d]", tag, cyc),  alu_a,       expA.pop_front());
                checkOutput($sformatf("%s:alu_b[c%0d]", tag, cyc),  alu_b,       expB.pop_front());
            end else begin
                checkOutput($sformatf("%s:extra_cycle[c%0d]", tag, cyc), 64'd1, 64'd0);
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, ":latency"},     64'(cyc),          64'(v.expLat));
        checkOutput({tag, ":passes_left"}, 64'(expOp.size()), 64'd0);
        checkResults(v, tag);
        for (int s = 0; s < stall; s++) begin
            if (junk) begin
                in_valid = 1'b1;
                scrambleInputs();
            end
            @(negedge clk);
            checkResults(v, $sformatf("%s:hold%0d", tag, s));
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput({tag, ":out_valid_after"}, 64'(out_valid), 64'd0);
        checkOutput({tag, ":in_ready_after"},  64'(in_ready),  64'd1);
        checkOutput({tag, ":busy_after"},      64'(busy),      64'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ":in_ready"},      64'(in_ready),     64'd1);
        checkOutput({tag, ":busy"},          64'(busy),         64'd0);
        checkOutput({tag, ":out_valid"},     64'(out_valid),    64'd0);
        checkOutput({tag, ":result"},        result,            64'd0);
        checkOutput({tag, ":zero"},          64'(zero),         64'd0);
        checkOutput({tag, ":branch_target"}, branch_target,     64'd0);
        checkOutput({tag, ":branch_taken"},  64'(branch_taken), 64'd0);
        checkOutput({tag, ":alu_op"},        64'(alu_op),       64'(OP_ADD));
        checkOutput({tag, ":alu_a"},         alu_a,             64'd0);
        checkOutput({tag, ":alu_b"},         alu_b,             64'd0);
    endtask

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        vec_t table_v[$];
        vec_t v;
        vec_t t1;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pc        = '0;
        imm       = '0;
        rs1_data  = '0;
        rs2_data  = '0;
        alu_src   = 1'b0;
        branch    = 1'b0;
        alu_ctrl  = '0;

        // Directed vectors with hand-computed expectations.
        t1 = '{64'h0, 64'h0, 64'd5, 64'd7, 1'b0, 1'b0, OP_ADD,
               64'd12, 1'b0, 64'h0, 1'b0, 2};
        table_v.push_back(t1);
        table_v.push_back('{64'h1000, 64'h8, 64'h55, 64'h55, 1'b0, 1'b1, OP_SUB,
                            64'h0, 1'b1, 64'h1010, 1'b1, 4});
        table_v.push_back('{64'h1000, 64'h8, 64'h55, 64'h54, 1'b0, 1'b1, OP_SUB,
                            64'h1, 1'b0, 64'h1010, 1'b0, 4});
        table_v.push_back('{64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'h3, 64'h3, 1'b0, 1'b1, OP_SUB,
                            64'h0, 1'b1, 64'h10, 1'b1, 4});
        table_v.push_back('{64'h0, 64'h0F, 64'hF0, 64'hFFFF, 1'b1, 1'b0, OP_OR,
                            64'hFF, 1'b0, 64'h0, 1'b0, 2});
        table_v.push_back('{64'h40, 64'h4, 64'hF0, 64'h0F, 1'b0, 1'b0, OP_AND,
                            64'h0, 1'b1, 64'h0, 1'b0, 2});
        table_v.push_back('{64'h0, 64'h0, 64'hA5, 64'h5A, 1'b0, 1'b0, 4'b1111,
                            64'hFF, 1'b0, 64'h0, 1'b0, 2});
        table_v.push_back('{64'h8000, 64'h8000_0000_0000_0001, 64'h7, 64'h7, 1'b0, 1'b1, OP_SUB,
                            64'h0, 1'b1, 64'h8002, 1'b1, 4});

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkResetState("reset");

        $display("[TB] directed table");
        for (int i = 0; i < table_v.size(); i++)
            runOp(table_v[i], 0, 1'b0, $sformatf("vec%0d", i));

        $display("[TB] backpressure with ignored in_valid pulses");
        runOp(t1, 3, 1'b1, "bp");

        $display("[TB] reset during SHIFT");
        v = table_v[2];
        out_ready = 1'b1;
        applyStimulus(v);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst:in_shift_alu_op", 64'(alu_op), 64'(OP_SLL));
        checkOutput("rst:pre_result",      result,      64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkResetState("rst");
        repeat (4) begin
            @(negedge clk);
            checkOutput("rst:no_out_valid", 64'(out_valid), 64'd0);
        end
        runOp(t1, 0, 1'b0, "rst:t1");

        $display("[TB] random ops");
        for (int n = 0; n < 40; n++) begin
            logic [3:0] ctrls[6];
            ctrls = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLL, OP_SLT};
            v.pc      = {$urandom, $urandom};
            v.imm     = {$urandom, $urandom};
            v.rs1     = {$urandom, $urandom};
            v.rs2     = ($urandom_range(0, 2) == 0) ? v.rs1 : {$urandom, $urandom};
            v.alu_src = ($urandom_range(0, 3) == 0);
            v.branch  = ($urandom_range(0, 1) == 1);
            v.ctrl    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                    : ctrls[$urandom_range(0, 5)];
            v = refModel(v);
            runOp(v, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
